// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- MBIST sequencer driving an external up/down address counter
module mbist_march_ctrl #(
   parameter int length     = 10,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [length-1:0]     ctr_d_in,
   output logic                  ctr_ld,
   output logic                  ctr_u_d,
   output logic                  ctr_cen,
   input  logic [length-1:0]     ctr_q,
   input  logic                  ctr_cout,
   output logic [length-1:0]     mem_addr,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [data_width-1:0] mem_wdata,
   input  logic [data_width-1:0] mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [length-1:0]     fail_addr,
   output logic [2:0]            fail_elem
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_RD   = 3'd3;
   localparam logic [2:0] S_CMP  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  done_q, done_d;
   logic                  fail_q, fail_d;
   logic [length-1:0]     fail_addr_q, fail_addr_d;
   logic [2:0]            fail_elem_q, fail_elem_d;

   logic                  elem_up;
   logic                  exp_ones;
   logic                  wr_ones;
   logic [data_width-1:0] exp_data;
   logic                  mismatch;

   // E3/E4 run downward; E2/E4 read back ones; E1/E3 write ones
   always_comb begin
      elem_up  = !((elem_q == 3'd3) || (elem_q == 3'd4));
      exp_ones = (elem_q == 3'd2) || (elem_q == 3'd4);
      wr_ones  = (elem_q == 3'd1) || (elem_q == 3'd3);
      exp_data = exp_ones ? {data_width{1'b1}} : {data_width{1'b0}};
      mismatch = (state_q == S_CMP) && (mem_rdata != exp_data);
   end

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      done_d      = done_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      ctr_ld      = 1'b0;
      ctr_cen     = 1'b0;
      ctr_u_d     = (state_q != S_IDLE) && elem_up;
      ctr_d_in    = '0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_wdata   = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               elem_d      = 3'd0;
               done_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = 3'd0;
            end
         end
         S_LOAD: begin
            ctr_ld   = 1'b1;
            ctr_cen  = 1'b1;
            ctr_d_in = elem_up ? {length{1'b0}} : {length{1'b1}};
            state_d  = (elem_q == 3'd0) ? S_WR : S_RD;
         end
         S_WR: begin
            mem_we = 1'b1;
            if (!ctr_cout) begin
               ctr_cen = 1'b1;
            end else begin
               elem_d  = 3'd1;
               state_d = S_LOAD;
            end
         end
         S_RD: begin
            mem_re  = 1'b1;
            state_d = S_CMP;
         end
         S_CMP: begin
            if (elem_q != 3'd5) begin
               mem_we    = 1'b1;
               mem_wdata = wr_ones ? {data_width{1'b1}} : {data_width{1'b0}};
            end
            // Only the first mismatch is recorded; the run always completes
            if (mismatch) begin
               fail_d = 1'b1;
               if (!fail_q) begin
                  fail_addr_d = ctr_q;
                  fail_elem_d = elem_q;
               end
            end
            if (!ctr_cout) begin
               ctr_cen = 1'b1;
               state_d = S_RD;
            end else if (elem_q != 3'd5) begin
               elem_d  = elem_q + 3'd1;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign mem_addr  = ctr_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed bench for mbist_march_ctrl with counter and SRAM models
module tb_mbist_march_ctrl;
   localparam int LEN = 3;
   localparam int DW  = 8;
   localparam int NW  = 8;

   logic           clk;
   logic           rst;
   logic           start;
   logic [LEN-1:0] ctr_d_in;
   logic           ctr_ld;
   logic           ctr_u_d;
   logic           ctr_cen;
   logic [LEN-1:0] ctr_q;
   logic           ctr_cout;
   logic [LEN-1:0] mem_addr;
   logic           mem_we;
   logic           mem_re;
   logic [DW-1:0]  mem_wdata;
   logic [DW-1:0]  mem_rdata;
   logic           busy;
   logic           done;
   logic           fail;
   logic [LEN-1:0] fail_addr;
   logic [2:0]     fail_elem;

   int errors = 0;
   int checks = 0;
   int n;
   bit overlap;
   int e3_addrs[$];
   int down_loads[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mbist_march_ctrl #(.length(LEN), .data_width(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ctr_d_in  (ctr_d_in),
      .ctr_ld    (ctr_ld),
      .ctr_u_d   (ctr_u_d),
      .ctr_cen   (ctr_cen),
      .ctr_q     (ctr_q),
      .ctr_cout  (ctr_cout),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem)
   );

   logic [LEN-1:0] cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else if (ctr_cen) begin
         if (ctr_ld)       cnt_q <= ctr_d_in;
         else if (ctr_u_d) cnt_q <= cnt_q + 1'b1;
         else              cnt_q <= cnt_q - 1'b1;
      end
   end
   assign ctr_q    = cnt_q;
   assign ctr_cout = ctr_u_d ? (&cnt_q) : ~(|cnt_q);

   // SRAM with per-address stuck-at-1 / stuck-at-0 masks applied on read
   logic [DW-1:0] mem [NW];
   logic [DW-1:0] sa1 [NW];
   logic [DW-1:0] sa0 [NW];
   logic [DW-1:0] rd_q;
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) rd_q <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
   end
   assign mem_rdata = rd_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input int start_at, input int abort_at);
      n = 0;
      overlap = 1'b0;
      e3_addrs.delete();
      down_loads.delete();
      while (busy && n < 2000) begin
         n++;
         if (mem_we && mem_re) overlap = 1'b1;
         if (mem_we && !ctr_u_d && mem_wdata == 8'hFF) e3_addrs.push_back(int'(mem_addr));
         if (ctr_ld && !ctr_u_d) down_loads.push_back(int'(ctr_d_in));
         if (n == abort_at) break;
         start = (n == start_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         sa1[i] = '0;
         sa0[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("reset_status", {busy, done, fail, fail_addr, fail_elem}, 32'd0);
      chk("reset_strobes", {mem_we, mem_re, ctr_ld, ctr_cen, ctr_u_d, ctr_d_in, mem_wdata}, 32'd0);
      rst = 1'b0;

      // Fault-free run
      pulse_start();
      run(-1, -1);
      chk("clean_busy_cycles", n, 94);
      chk("clean_done", done, 1);
      chk("clean_busy_low", busy, 0);
      chk("clean_fail", fail, 0);
      chk("clean_fail_addr", fail_addr, 0);
      chk("clean_fail_elem", fail_elem, 0);
      chk("we_re_overlap", overlap, 0);
      chk("e3_addr_count", e3_addrs.size(), 8);
      for (int i = 0; i < 8; i++)
         if (i < e3_addrs.size()) chk("e3_addr_order", e3_addrs[i], 7 - i);
      chk("down_load_count", down_loads.size(), 2);
      if (down_loads.size() > 0) chk("e3_load_d_in", down_loads[0], 7);

      // Bit 0 of address 5 stuck at 1: caught by the first r0 in E1
      sa1[5] = 8'h01;
      pulse_start();
      run(-1, -1);
      chk("sa1_busy_cycles", n, 94);
      chk("sa1_done", done, 1);
      chk("sa1_fail", fail, 1);
      chk("sa1_fail_addr", fail_addr, 5);
      chk("sa1_fail_elem", fail_elem, 1);
      sa1[5] = 8'h00;

      // Bit 3 of address 2 stuck at 0: caught in E2, E4 hit must not overwrite
      sa0[2] = 8'h08;
      pulse_start();
      run(-1, -1);
      chk("sa0_busy_cycles", n, 94);
      chk("sa0_done", done, 1);
      chk("sa0_fail", fail, 1);
      chk("sa0_fail_addr", fail_addr, 2);
      chk("sa0_fail_elem", fail_elem, 2);
      sa0[2] = 8'h00;

      // Async abort at cycle 40 of a failing run
      sa1[5] = 8'h01;
      pulse_start();
      chk("start_clears_done", done, 0);
      run(-1, 40);
      chk("abort_reached", n, 40);
      chk("abort_pre_fail", fail, 1);
      #1 rst = 1'b1;
      #1;
      chk("abort_status", {busy, done, fail, fail_addr, fail_elem}, 32'd0);
      chk("abort_strobes", {mem_we, mem_re, ctr_ld, ctr_cen, ctr_u_d, ctr_d_in, mem_wdata}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sa1[5] = 8'h00;
      pulse_start();
      run(-1, -1);
      chk("post_abort_cycles", n, 94);
      chk("post_abort_done", done, 1);
      chk("post_abort_fail", fail, 0);

      // start while busy is ignored
      pulse_start();
      run(20, -1);
      chk("busy_start_cycles", n, 94);
      chk("busy_start_done", done, 1);

      // start after done restarts
      pulse_start();
      chk("restart_done_low", done, 0);
      chk("restart_busy", busy, 1);
      run(-1, -1);
      chk("restart_cycles", n, 94);
      chk("restart_done", done, 1);
      chk("restart_fail", fail, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
